// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache between the CPU
// memory stage and a request/acknowledge main-memory port.
module data_cache #(
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_sext,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int WORD_BITS = $clog2(LINE_WORDS);
  localparam int SET_BITS  = $clog2(SETS);
  localparam int TAG_W     = 30 - WORD_BITS - SET_BITS;
  localparam int CNT_W     = (WORD_BITS > 0) ? WORD_BITS : 1;

  // Handshake: mem_req (with mem_we/mem_addr/mem_wdata/mem_wstrb) is held
  // stable until the cycle mem_ack is high; that cycle completes the beat.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_WRITE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SETS-1:0]  valid_q, valid_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [TAG_W-1:0] tag_q [SETS];
  logic [31:0]      data_q [SETS][LINE_WORDS];

  logic [1:0]          offset;
  logic [SET_BITS-1:0] set_idx;
  logic [TAG_W-1:0]    addr_tag;
  logic [CNT_W-1:0]    word_idx;
  logic                hit;
  logic [31:0]         rd_word;

  assign offset   = cpu_addr[1:0];
  assign set_idx  = cpu_addr[2+WORD_BITS +: SET_BITS];
  assign addr_tag = cpu_addr[31 -: TAG_W];

  generate
    if (WORD_BITS > 0) begin : g_word
      assign word_idx = cpu_addr[2 +: WORD_BITS];
    end else begin : g_noword
      assign word_idx = '0;
    end
  endgenerate

  assign hit     = valid_q[set_idx] && (tag_q[set_idx] == addr_tag);
  assign rd_word = data_q[set_idx][word_idx];

  // Store lanes: strobe mask and data replicated into every lane.
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  always_comb begin
    st_strb = 4'b1111;
    st_data = cpu_wdata;
    case (cpu_size)
      2'b00: begin
        st_strb = 4'b0001 << offset;
        st_data = {4{cpu_wdata[7:0]}};
      end
      2'b01: begin
        st_strb = offset[1] ? 4'b1100 : 4'b0011;
        st_data = {2{cpu_wdata[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = cpu_wdata;
      end
    endcase
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_val;
  always_comb begin
    ld_byte  = rd_word[{offset, 3'b000} +: 8];
    ld_half  = offset[1] ? rd_word[31:16] : rd_word[15:0];
    load_val = rd_word;
    case (cpu_size)
      2'b00:   load_val = {{24{cpu_sext & ld_byte[7]}}, ld_byte};
      2'b01:   load_val = {{16{cpu_sext & ld_half[15]}}, ld_half};
      default: load_val = rd_word;
    endcase
  end

  logic             load_ok;
  logic             tag_we;
  logic             data_we;
  logic [CNT_W-1:0] data_widx;
  logic [31:0]      data_wdata;
  logic [3:0]       data_wmask;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    load_ok    = 1'b0;
    cpu_stall  = 1'b0;
    tag_we     = 1'b0;
    data_we    = 1'b0;
    data_widx  = word_idx;
    data_wdata = st_data;
    data_wmask = st_strb;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            cpu_stall = 1'b1;
            state_d   = S_WRITE;
          end else if (hit) begin
            load_ok = 1'b1;
          end else begin
            cpu_stall = 1'b1;
            state_d   = S_REFILL;
            cnt_d     = '0;
          end
        end
      end
      S_REFILL: begin
        cpu_stall = 1'b1;
        if (mem_ack) begin
          data_we    = 1'b1;
          data_widx  = cnt_q;
          data_wdata = mem_rdata;
          data_wmask = 4'b1111;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(LINE_WORDS - 1)) begin
            valid_d[set_idx] = 1'b1;
            tag_we           = 1'b1;
            cnt_d            = '0;
            state_d          = S_IDLE;
          end
        end
      end
      S_WRITE: begin
        // Stall drops in the ack cycle so the store retires with the write.
        cpu_stall = !mem_ack;
        if (mem_ack) begin
          data_we = hit;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    mem_req_d = (state_d != S_IDLE);
    mem_we_d  = (state_d == S_WRITE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      valid_q   <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && tag_we) tag_q[set_idx] <= addr_tag;
    if (!rst && data_we) begin
      for (int b = 0; b < 4; b++) begin
        if (data_wmask[b]) data_q[set_idx][data_widx][8*b +: 8] <= data_wdata[8*b +: 8];
      end
    end
  end

  logic [31:0] line_base;
  assign line_base = cpu_addr & ~32'(LINE_WORDS * 4 - 1);

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    case (state_q)
      S_REFILL: mem_addr = line_base | (32'(cnt_q) << 2);
      S_WRITE: begin
        mem_addr  = cpu_addr & ~32'h3;
        mem_wdata = st_data;
        mem_wstrb = st_strb;
      end
      default: mem_addr = '0;
    endcase
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign cpu_rdata = load_ok ? load_val : 32'h0;

endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: directed scenarios then random loads/stores, checked
// against a main-memory array plus a per-set resident-line model.
module tb_data_cache;

  localparam int SETS = 16;
  localparam int LW   = 4;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [1:0]  cpu_size;
  logic        cpu_sext;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack   = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  data_cache #(.SETS(SETS), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_size(cpu_size), .cpu_sext(cpu_sext),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [68:0] got, input logic [68:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic report();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
  endtask

  // main memory and reference cache occupancy
  logic [31:0] mem [logic [31:0]];
  logic [31:0] res_line [SETS];
  bit          res_valid [SETS];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a / (4 * LW);
  endfunction

  function automatic int set_of(input logic [31:0] a);
    return int'(line_of(a) % SETS);
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  // scoreboard of expected memory beats: {we, wstrb, addr, masked wdata}
  logic [68:0] exp_q[$];
  int lat      = 0;
  int wait_cnt = 0;
  int acks     = 0;

  // memory responder: acks after 'lat' waiting cycles
  always begin
    logic [31:0] w;
    logic [68:0] obs;
    @(posedge clk);
    #2;
    if (mem_req) begin
      if (wait_cnt >= lat) begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
        acks++;
        if (mem_we) begin
          w = mem_rd(mem_addr);
          for (int b = 0; b < 4; b++) if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
          mem[mem_addr] = w;
          obs = {1'b1, mem_wstrb, mem_addr, mem_wdata & lane_mask(mem_wstrb)};
        end else begin
          mem_rdata = mem_rd(mem_addr);
          obs = {1'b0, 4'b0, mem_addr, 32'h0};
        end
        chk("mem_beat_expected", 69'(exp_q.size() > 0), 69'(1));
        if (exp_q.size() > 0) chk("mem_beat", obs, exp_q.pop_front());
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
  end

  // driver: one CPU access held until it retires; checks stall length and data
  task automatic access(input bit we, input logic [31:0] a, input logic [1:0] sz,
                        input bit sx, input logic [31:0] wd,
                        output logic [31:0] rd, output int st);
    int          s;
    int          exp_st;
    bit          hit;
    logic [3:0]  strb;
    logic [31:0] dat;
    logic [31:0] w;
    logic [31:0] v;
    int          sh;
    s   = set_of(a);
    hit = res_valid[s] && (res_line[s] == line_of(a));
    if (we) begin
      if (sz == 2'b00) begin
        sh = 8 * int'(a % 4);
        strb = 4'(1 << (a % 4));
        dat  = (wd & 32'hFF) << sh;
      end else if (sz == 2'b01) begin
        sh = ((a % 4) >= 2) ? 16 : 0;
        strb = (sh == 16) ? 4'b1100 : 4'b0011;
        dat  = (wd & 32'hFFFF) << sh;
      end else begin
        strb = 4'b1111;
        dat  = wd;
      end
      exp_q.push_back({1'b1, strb, a & ~32'h3, dat & lane_mask(strb)});
      exp_st = lat + 1;
    end else if (!hit) begin
      for (int i = 0; i < LW; i++) exp_q.push_back({1'b0, 4'b0, line_of(a) * (4 * LW) + 32'(4 * i), 32'h0});
      exp_st = LW * (lat + 1) + 1;
    end else begin
      exp_st = 0;
    end
    @(posedge clk);
    #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_size = sz; cpu_sext = sx; cpu_wdata = wd;
    st = 0;
    @(negedge clk);
    while (cpu_stall && st < 1000) begin
      st++;
      @(negedge clk);
    end
    if (cpu_stall) begin
      chk("access_timeout", 69'(st), 69'(exp_st));
      report();
      $finish;
    end
    rd = cpu_rdata;
    chk(we ? "store_stall_cycles" : "load_stall_cycles", 69'(st), 69'(exp_st));
    if (we) begin
      chk("store_rdata_zero", 69'(cpu_rdata), 69'(0));
    end else begin
      if (!hit) begin
        res_valid[s] = 1'b1;
        res_line[s]  = line_of(a);
      end
      w = mem_rd(a & ~32'h3);
      if (sz == 2'b00) begin
        v = (w >> (8 * (a % 4))) & 32'hFF;
        if (sx && v >= 32'h80) v = v + 32'hFFFF_FF00;
      end else if (sz == 2'b01) begin
        v = (w >> (((a % 4) >= 2) ? 16 : 0)) & 32'hFFFF;
        if (sx && v >= 32'h8000) v = v + 32'hFFFF_0000;
      end else begin
        v = w;
      end
      chk("load_data", 69'(cpu_rdata), 69'(v));
    end
  endtask

  initial begin
    logic [31:0] rd;
    int          st;
    int          k;
    int          start;
    logic [31:0] a;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
    cpu_wdata = '0; cpu_size = 2'b10; cpu_sext = 1'b0;
    for (int i = 0; i < SETS; i++) res_valid[i] = 1'b0;
    mem[32'h100] = 32'h1111_1111;
    mem[32'h104] = 32'h2222_2222;
    mem[32'h108] = 32'h3333_3333;
    mem[32'h10C] = 32'h80FF_0000;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_req", 69'(mem_req), 69'(0));
    chk("reset_stall", 69'(cpu_stall), 69'(0));
    chk("reset_rdata", 69'(cpu_rdata), 69'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // refill then hit
    lat = 0;
    access(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, rd, st);
    chk("t1_miss_stall", 69'(st), 69'(5));
    chk("t1_word0", 69'(rd), 69'(32'h1111_1111));
    access(1'b0, 32'h108, 2'b10, 1'b0, 32'h0, rd, st);
    chk("t1_hit_stall", 69'(st), 69'(0));
    chk("t1_word2", 69'(rd), 69'(32'h3333_3333));

    // byte/half extraction and extension
    access(1'b0, 32'h10F, 2'b00, 1'b1, 32'h0, rd, st);
    chk("t2_byte_sext", 69'(rd), 69'(32'hFFFF_FF80));
    access(1'b0, 32'h10F, 2'b00, 1'b0, 32'h0, rd, st);
    chk("t2_byte_zext", 69'(rd), 69'(32'h0000_0080));
    access(1'b0, 32'h10E, 2'b01, 1'b1, 32'h0, rd, st);
    chk("t2_half_sext", 69'(rd), 69'(32'hFFFF_80FF));

    // store byte into a cached word
    access(1'b1, 32'h101, 2'b00, 1'b0, 32'h0000_00AB, rd, st);
    access(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, rd, st);
    chk("t3_store_hit_data", 69'(rd), 69'(32'h1111_AB11));

    // store miss does not allocate
    access(1'b1, 32'h2000, 2'b10, 1'b0, 32'hCAFE_F00D, rd, st);
    access(1'b0, 32'h2000, 2'b10, 1'b0, 32'h0, rd, st);
    chk("t4_no_allocate_stall", 69'(st), 69'(5));
    chk("t4_data", 69'(rd), 69'(32'hCAFE_F00D));

    // set conflict evicts
    access(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, rd, st);
    access(1'b0, 32'h500, 2'b10, 1'b0, 32'h0, rd, st);
    access(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, rd, st);
    chk("t5_reload_miss_stall", 69'(st), 69'(5));

    // reset during the second refill beat
    lat = 0;
    for (int i = 0; i < LW; i++) exp_q.push_back({1'b0, 4'b0, 32'h500 + 32'(4 * i), 32'h0});
    start = acks;
    @(posedge clk);
    #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h500; cpu_size = 2'b10; cpu_sext = 1'b0;
    k = 0;
    while (acks < start + 1 && k < 100) begin
      @(posedge clk);
      k++;
    end
    chk("t6_first_beat_seen", 69'(acks - start), 69'(1));
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    chk("t6_mem_req_dropped", 69'(mem_req), 69'(0));
    chk("t6_stall_released", 69'(cpu_stall), 69'(0));
    chk("t6_rdata_zero", 69'(cpu_rdata), 69'(0));
    chk("t6_abandoned_beats", 69'(exp_q.size()), 69'(LW - 2));
    exp_q.delete();
    for (int i = 0; i < SETS; i++) res_valid[i] = 1'b0;
    access(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, rd, st);
    chk("t6_after_reset_miss", 69'(st), 69'(5));

    // random loads and stores over a few conflicting lines
    for (int n = 0; n < 250; n++) begin
      lat = $urandom_range(0, 2);
      a = 32'h1000 | (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 2)) << 4)
          | 32'($urandom_range(0, 15));
      access($urandom_range(0, 3) == 0, a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, rd, st);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1 cpu_req = 1'b0;
      end
    end

    @(posedge clk);
    #1 cpu_req = 1'b0;
    repeat (4) @(posedge clk);
    chk("mem_queue_drained", 69'(exp_q.size()), 69'(0));
    report();
    $finish;
  end

endmodule
